// File: rtl/acc_bank_pkg.sv
// Shared types and helpers for the rotating accumulation buffer:
// bank-pointer arithmetic modulo NBANK and the saturating/wrapping adder.
package acc_bank_pkg;

  // Widest accumulator the adder helper can evaluate (two guard bits kept free).
  localparam int MAXW = 64;

  // Bank index as used by the pointer helpers; callers truncate to their pointer width.
  typedef int unsigned bank_idx_t;

  // Adder result: low OWID bits of val carry the new bank value.
  typedef struct packed {
    logic            ovf;
    logic [MAXW-1:0] val;
  } add_res_t;

  // Next bank index, wrapping from nbank-1 back to 0.
  function automatic bank_idx_t ptr_inc(input bank_idx_t p, input bank_idx_t nbank);
    return (p == nbank - 1) ? bank_idx_t'(0) : p + 1;
  endfunction

  // Previous bank index, wrapping from 0 back to nbank-1.
  function automatic bank_idx_t ptr_dec(input bank_idx_t p, input bank_idx_t nbank);
    return (p == 0) ? nbank - 1 : p - 1;
  endfunction

  // Adds two operands already extended to MAXW bits and fits the sum into owid bits.
  // The sum is exact at MAXW bits, so range checks against the owid limits are exact too.
  function automatic add_res_t sat_add(input logic [MAXW-1:0] a,
                                       input logic [MAXW-1:0] b,
                                       input int              owid,
                                       input bit              is_signed,
                                       input bit              sat);
    add_res_t r;
    longint   sum;
    longint   max_v;
    longint   min_v;
    sum = $signed(a) + $signed(b);
    if (is_signed) begin
      max_v = (longint'(1) << (owid - 1)) - 1;
      min_v = -(longint'(1) << (owid - 1));
    end else begin
      max_v = (longint'(1) << owid) - 1;
      min_v = 0;
    end
    r.ovf = (sum > max_v) || (sum < min_v);
    if (sat && (sum > max_v)) begin
      r.val = max_v;
    end else if (sat && (sum < min_v)) begin
      r.val = min_v;
    end else begin
      // Wrapping keeps the low owid bits, which the caller slices off.
      r.val = sum;
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_bank_lane.sv
// One accumulation lane: NBANK bank registers with sticky overflow bits,
// the lane adder, and the read mux for the most recently closed bank.
module acc_bank_lane
  import acc_bank_pkg::*;
#(
  parameter int NBANK  = 2,
  parameter int IWID   = 7,
  parameter int OWID   = 17,
  parameter int SIGNED = 0,
  parameter int SAT    = 0,
  parameter int PW     = $clog2(NBANK)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_i,
  input  logic            valid_i,
  input  logic            clear_i,
  input  logic            swap_i,
  input  logic [PW-1:0]   acc_ptr_i,
  input  logic [PW-1:0]   rd_ptr_i,
  input  logic [IWID-1:0] data_i,
  output logic [OWID-1:0] rd_data_o,
  output logic            rd_ovf_o
);

  logic [OWID-1:0]  bank_q [NBANK];
  logic [OWID-1:0]  bank_d [NBANK];
  logic [NBANK-1:0] ovf_q;
  logic [NBANK-1:0] ovf_d;
  logic [PW-1:0]    nxt_ptr;
  logic [MAXW-1:0]  a_ext;
  logic [MAXW-1:0]  b_ext;
  add_res_t         add_res;
  logic             unused_hi;

  // Bank that becomes the accumulating one after a swap; it is zeroed on arrival.
  assign nxt_ptr = PW'(ptr_inc(bank_idx_t'(acc_ptr_i), NBANK));

  // Extend the current bank value and the lane input, then add with saturation or wrap.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{(MAXW-OWID){bank_q[acc_ptr_i][OWID-1]}}, bank_q[acc_ptr_i]};
      b_ext = {{(MAXW-IWID){data_i[IWID-1]}}, data_i};
    end else begin
      a_ext = {{(MAXW-OWID){1'b0}}, bank_q[acc_ptr_i]};
      b_ext = {{(MAXW-IWID){1'b0}}, data_i};
    end
    add_res = sat_add(a_ext, b_ext, OWID, SIGNED != 0, SAT != 0);
  end

  // Only the low OWID bits of the adder result are stored.
  assign unused_hi = ^add_res.val[MAXW-1:OWID];

  // Next bank contents: clear beats add, and a swap zeroes the incoming bank at the same edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bank_d = bank_q;
    ovf_d  = ovf_q;
    if (!hold_i) begin
      if (clear_i) begin
        bank_d[acc_ptr_i] = '0;
        ovf_d[acc_ptr_i]  = 1'b0;
      end else if (valid_i) begin
        bank_d[acc_ptr_i] = add_res.val[OWID-1:0];
        ovf_d[acc_ptr_i]  = ovf_q[acc_ptr_i] | add_res.ovf;
      end
      if (swap_i) begin
        bank_d[nxt_ptr] = '0;
        ovf_d[nxt_ptr]  = 1'b0;
      end
    end
  end

  // Bank and overflow registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments; the bank array is reset element by
    // element because the all-zero contents are visible on the read port after reset.
    if (rst) begin
      for (int b = 0; b < NBANK; b++) begin
        bank_q[b] <= '0;
      end
      ovf_q <= '0;
    end else begin
      bank_q <= bank_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rd_data_o = bank_q[rd_ptr_i];
  assign rd_ovf_o  = ovf_q[rd_ptr_i];

endmodule

// File: rtl/acc_bank_rotator.sv
// Multi-channel rotating accumulation buffer: NCH lanes accumulate into the
// current bank while the most recently closed bank is presented downstream.
module acc_bank_rotator
  import acc_bank_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int NBANK  = 2,
  parameter int IWID   = 7,
  parameter int OWID   = 17,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iValid,
  input  logic                       iClear,
  input  logic                       iHold,
  input  logic                       iSwap,
  input  logic [NCH*IWID-1:0]        iData,
  output logic [NCH*OWID-1:0]        oData,
  output logic [NCH-1:0]             oOvf,
  output logic                       oValid,
  output logic [$clog2(NBANK)-1:0]   oBank
);

  localparam int PW = $clog2(NBANK);

  // Reject configurations the datapath cannot represent.
  if (NBANK < 2) begin : g_chk_nbank
    $error("acc_bank_rotator: NBANK must be at least 2");
  end
  if (OWID <= IWID) begin : g_chk_owid
    $error("acc_bank_rotator: OWID must exceed IWID");
  end
  if (OWID > MAXW - 2) begin : g_chk_maxw
    $error("acc_bank_rotator: OWID too wide for the adder helper");
  end

  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;
  logic [PW-1:0] rd_ptr;
  logic          valid_q;
  logic          valid_d;

  // An accepted swap advances the accumulating bank and raises the completion strobe.
  always_comb begin
    acc_d   = acc_q;
    valid_d = 1'b0;
    if (!iHold && iSwap) begin
      acc_d   = PW'(ptr_inc(bank_idx_t'(acc_q), NBANK));
      valid_d = 1'b1;
    end
  end

  // Shared pointer and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

  // The read bank is always the one just behind the accumulating bank.
  assign rd_ptr = PW'(ptr_dec(bank_idx_t'(acc_q), NBANK));

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    acc_bank_lane #(
      .NBANK (NBANK),
      .IWID  (IWID),
      .OWID  (OWID),
      .SIGNED(SIGNED),
      .SAT   (SAT),
      .PW    (PW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (iHold),
      .valid_i  (iValid),
      .clear_i  (iClear),
      .swap_i   (iSwap),
      .acc_ptr_i(acc_q),
      .rd_ptr_i (rd_ptr),
      .data_i   (iData[k*IWID +: IWID]),
      .rd_data_o(oData[k*OWID +: OWID]),
      .rd_ovf_o (oOvf[k])
    );
  end

  assign oValid = valid_q;
  assign oBank  = acc_q;

endmodule

// File: tb/tb_acc_bank_rotator.sv
// Self-checking bench: four configurations share one stimulus stream and are
// compared with a behavioural bank model plus hand-computed scenario values.
module tb_acc_bank_rotator;

  localparam int ND   = 4;
  localparam int NCH  = 4;
  localparam int IWID = 7;
  localparam int MAXB = 3;

  logic clk = 1'b0;
  logic rst, iValid, iClear, iHold, iSwap;
  logic [NCH*IWID-1:0] iData;

  logic [NCH*17-1:0] od0;
  logic [NCH*9-1:0]  od1;
  logic [NCH*8-1:0]  od2, od3;
  logic [NCH-1:0]    ov0, ov1, ov2, ov3;
  logic              ovl0, ovl1, ovl2, ovl3;
  logic              ob0, ob2, ob3;
  logic [1:0]        ob1;

  logic [63:0] obs_data  [ND][NCH];
  logic        obs_ovf   [ND][NCH];
  logic        obs_valid [ND];
  logic [31:0] obs_bank  [ND];

  longint m_bank  [ND][MAXB][NCH];
  bit     m_ovf   [ND][MAXB][NCH];
  int     m_ptr   [ND];
  bit     m_valid [ND];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  acc_bank_rotator #(.NCH(NCH), .NBANK(2), .IWID(IWID), .OWID(17), .SIGNED(0), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .iValid(iValid), .iClear(iClear), .iHold(iHold), .iSwap(iSwap),
    .iData(iData), .oData(od0), .oOvf(ov0), .oValid(ovl0), .oBank(ob0));
  acc_bank_rotator #(.NCH(NCH), .NBANK(3), .IWID(IWID), .OWID(9), .SIGNED(0), .SAT(0)) dut1 (
    .clk(clk), .rst(rst), .iValid(iValid), .iClear(iClear), .iHold(iHold), .iSwap(iSwap),
    .iData(iData), .oData(od1), .oOvf(ov1), .oValid(ovl1), .oBank(ob1));
  acc_bank_rotator #(.NCH(NCH), .NBANK(2), .IWID(IWID), .OWID(8), .SIGNED(1), .SAT(1)) dut2 (
    .clk(clk), .rst(rst), .iValid(iValid), .iClear(iClear), .iHold(iHold), .iSwap(iSwap),
    .iData(iData), .oData(od2), .oOvf(ov2), .oValid(ovl2), .oBank(ob2));
  acc_bank_rotator #(.NCH(NCH), .NBANK(2), .IWID(IWID), .OWID(8), .SIGNED(1), .SAT(0)) dut3 (
    .clk(clk), .rst(rst), .iValid(iValid), .iClear(iClear), .iHold(iHold), .iSwap(iSwap),
    .iData(iData), .oData(od3), .oOvf(ov3), .oValid(ovl3), .oBank(ob3));

  // Gather every DUT's lanes into uniform arrays.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      obs_data[0][k] = 64'(od0[k*17 +: 17]);
      obs_data[1][k] = 64'(od1[k*9 +: 9]);
      obs_data[2][k] = 64'(od2[k*8 +: 8]);
      obs_data[3][k] = 64'(od3[k*8 +: 8]);
      obs_ovf[0][k]  = ov0[k];
      obs_ovf[1][k]  = ov1[k];
      obs_ovf[2][k]  = ov2[k];
      obs_ovf[3][k]  = ov3[k];
    end
    obs_valid[0] = ovl0;
    obs_valid[1] = ovl1;
    obs_valid[2] = ovl2;
    obs_valid[3] = ovl3;
    obs_bank[0]  = 32'(ob0);
    obs_bank[1]  = 32'(ob1);
    obs_bank[2]  = 32'(ob2);
    obs_bank[3]  = 32'(ob3);
  end

  function automatic int cfg_nb(input int d);
    return (d == 1) ? 3 : 2;
  endfunction
  function automatic int cfg_ow(input int d);
    return (d == 0) ? 17 : (d == 1) ? 9 : 8;
  endfunction
  function automatic bit cfg_sg(input int d);
    return d >= 2;
  endfunction
  function automatic bit cfg_sat(input int d);
    return d == 2;
  endfunction

  // Expected read-port value of lane k of configuration d, as OWID raw bits.
  function automatic logic [63:0] exp_data(input int d, input int k);
    int rd;
    rd = (m_ptr[d] + cfg_nb(d) - 1) % cfg_nb(d);
    return 64'(m_bank[d][rd][k]) & ((64'd1 << cfg_ow(d)) - 64'd1);
  endfunction
  function automatic bit exp_ovf(input int d, input int k);
    return m_ovf[d][(m_ptr[d] + cfg_nb(d) - 1) % cfg_nb(d)][k];
  endfunction

  // Behavioural model: banks hold true numeric values; one call per rising edge.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      int nb, p;
      longint m, hi, lo, s, v;
      nb = cfg_nb(d);
      m  = longint'(1) << cfg_ow(d);
      if (cfg_sg(d)) begin
        hi = m / 2 - 1;
        lo = -(m / 2);
      end else begin
        hi = m - 1;
        lo = 0;
      end
      if (rst) begin
        for (int b = 0; b < MAXB; b++)
          for (int k = 0; k < NCH; k++) begin
            m_bank[d][b][k] = 0;
            m_ovf[d][b][k]  = 0;
          end
        m_ptr[d]   = 0;
        m_valid[d] = 0;
      end else if (iHold) begin
        m_valid[d] = 0;
      end else begin
        p = m_ptr[d];
        if (iClear) begin
          for (int k = 0; k < NCH; k++) begin
            m_bank[d][p][k] = 0;
            m_ovf[d][p][k]  = 0;
          end
        end else if (iValid) begin
          for (int k = 0; k < NCH; k++) begin
            v = longint'(iData[k*IWID +: IWID]);
            if (cfg_sg(d) && v >= (longint'(1) << (IWID - 1))) v = v - (longint'(1) << IWID);
            s = m_bank[d][p][k] + v;
            if (s > hi || s < lo) begin
              m_ovf[d][p][k] = 1;
              if (cfg_sat(d)) s = (s > hi) ? hi : lo;
              else begin
                s = s % m;
                if (s < 0) s = s + m;
                if (cfg_sg(d) && s > hi) s = s - m;
              end
            end
            m_bank[d][p][k] = s;
          end
        end
        if (iSwap) begin
          p = (p + 1) % nb;
          for (int k = 0; k < NCH; k++) begin
            m_bank[d][p][k] = 0;
            m_ovf[d][p][k]  = 0;
          end
          m_ptr[d]   = p;
          m_valid[d] = 1;
        end else begin
          m_valid[d] = 0;
        end
      end
    end
  endtask

  // Advance one clock; the model sees the same inputs as the DUTs, outputs settle by +1.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < NCH; k++) iData[k*IWID +: IWID] = IWID'(v);
  endtask

  task automatic set_rand();
    for (int k = 0; k < NCH; k++) iData[k*IWID +: IWID] = IWID'($urandom);
  endtask

  task automatic idle_inputs();
    iValid = 0; iClear = 0; iHold = 0; iSwap = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) tick();
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (obs_valid[d] !== 1'b0) $display("FAIL reset_valid dut%0d got %b want 0", d, obs_valid[d]);
      else n_pass++;
      n_checks++;
      if (obs_bank[d] !== 32'd0) $display("FAIL reset_bank dut%0d got %0d want 0", d, obs_bank[d]);
      else n_pass++;
      for (int k = 0; k < NCH; k++) begin
        n_checks++;
        if (obs_data[d][k] !== 64'd0 || obs_ovf[d][k] !== 1'b0)
          $display("FAIL reset_data dut%0d lane%0d got %0h/%b want 0/0", d, k, obs_data[d][k], obs_ovf[d][k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_accumulate();
    do_reset();
    iData = {7'd4, 7'd3, 7'd2, 7'd1};
    iValid = 1;
    repeat (10) tick();
    iValid = 0;
    iSwap = 1;
    tick();
    iSwap = 0;
    n_checks++;
    if (ovl0 !== 1'b1) $display("FAIL acc_valid got %b want 1", ovl0);
    else n_pass++;
    n_checks++;
    if (ob0 !== 1'b1) $display("FAIL acc_bank got %0d want 1", ob0);
    else n_pass++;
    for (int k = 0; k < NCH; k++) begin
      n_checks++;
      if (obs_data[0][k] !== 64'(10 * (k + 1)))
        $display("FAIL acc_lane%0d got %0d want %0d", k, obs_data[0][k], 10 * (k + 1));
      else n_pass++;
    end
    tick();
    n_checks++;
    if (ovl0 !== 1'b0) $display("FAIL acc_valid_drop got %b want 0", ovl0);
    else n_pass++;
  endtask

  task automatic test_wrap3();
    int exp_val [4] = '{5, 10, 15, 5};
    int exp_bnk [4] = '{1, 2, 0, 1};
    do_reset();
    set_all(5);
    for (int e = 0; e < 4; e++) begin
      iValid = 1;
      repeat ((e < 3) ? e + 1 : 1) tick();
      iValid = 0;
      iSwap = 1;
      tick();
      iSwap = 0;
      n_checks++;
      if (ob1 !== 2'(exp_bnk[e]) || ovl1 !== 1'b1)
        $display("FAIL wrap3_bank epoch%0d got %0d/%b want %0d/1", e, ob1, ovl1, exp_bnk[e]);
      else n_pass++;
      for (int k = 0; k < NCH; k++) begin
        n_checks++;
        if (obs_data[1][k] !== 64'(exp_val[e]))
          $display("FAIL wrap3_data epoch%0d lane%0d got %0d want %0d", e, k, obs_data[1][k], exp_val[e]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_signed_sat();
    logic [63:0] ev;
    bit eo;
    do_reset();
    set_all(63);
    iValid = 1;
    repeat (3) tick();
    iValid = 0;
    iSwap = 1;
    tick();
    iSwap = 0;
    for (int d = 0; d < ND; d++) begin
      case (d)
        2:       begin ev = 64'd127;  eo = 1; end
        3:       begin ev = 64'hBD;   eo = 1; end
        default: begin ev = 64'd189;  eo = 0; end
      endcase
      for (int k = 0; k < NCH; k++) begin
        n_checks++;
        if (obs_data[d][k] !== ev || obs_ovf[d][k] !== eo)
          $display("FAIL sat dut%0d lane%0d got %0h/%b want %0h/%b", d, k, obs_data[d][k], obs_ovf[d][k], ev, eo);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_rand();
    iValid = 1;
    repeat (3) tick();
    iValid = 0;
    iSwap = 1;
    tick();
    iSwap = 0;
    iValid = 1;
    repeat (2) tick();
    for (int step = 0; step < 9; step++) begin
      idle_inputs();
      set_rand();
      if (step < 4) begin
        iHold = 1; iValid = 1; iSwap = 1; iClear = (step == 2);
      end else if (step == 6) begin
        iSwap = 1;
      end else if (step != 8) begin
        iValid = 1;
      end
      tick();
      if (step < 4) begin
        n_checks++;
        if (ovl0 !== 1'b0) $display("FAIL hold_strobe step%0d got %b want 0", step, ovl0);
        else n_pass++;
      end
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs_valid[d] !== m_valid[d] || obs_bank[d] !== 32'(m_ptr[d]))
          $display("FAIL hold_ctrl step%0d dut%0d got %b/%0d want %b/%0d",
                   step, d, obs_valid[d], obs_bank[d], m_valid[d], m_ptr[d]);
        else n_pass++;
        for (int k = 0; k < NCH; k++) begin
          n_checks++;
          if (obs_data[d][k] !== exp_data(d, k) || obs_ovf[d][k] !== exp_ovf(d, k))
            $display("FAIL hold_data step%0d dut%0d lane%0d got %0h/%b want %0h/%b",
                     step, d, k, obs_data[d][k], obs_ovf[d][k], exp_data(d, k), exp_ovf(d, k));
          else n_pass++;
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_swap_clear();
    do_reset();
    set_all(7);
    iValid = 1;
    repeat (6) tick();
    iClear = 1;
    iSwap = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (ovl0 !== 1'b1) $display("FAIL swclr_valid got %b want 1", ovl0);
    else n_pass++;
    for (int k = 0; k < NCH; k++) begin
      n_checks++;
      if (obs_data[0][k] !== 64'd0 || obs_ovf[0][k] !== 1'b0)
        $display("FAIL swclr_lane%0d got %0h/%b want 0/0", k, obs_data[0][k], obs_ovf[0][k]);
      else n_pass++;
    end
    // Accumulate, then reset with a swap pending: the swap must be lost.
    iValid = 1;
    repeat (3) tick();
    rst = 1;
    iSwap = 1;
    tick();
    rst = 0;
    idle_inputs();
    n_checks++;
    if (ob0 !== 1'b0 || ovl0 !== 1'b0 || ob1 !== 2'd0)
      $display("FAIL rst_mid_ctrl got %0d/%b/%0d want 0/0/0", ob0, ovl0, ob1);
    else n_pass++;
    n_checks++;
    if (od0 !== '0 || ov0 !== '0) $display("FAIL rst_mid_data got %0h/%0h want 0/0", od0, ov0);
    else n_pass++;
    iSwap = 1;
    tick();
    iSwap = 0;
    n_checks++;
    if (od0 !== '0 || ob0 !== 1'b1 || ovl0 !== 1'b1)
      $display("FAIL rst_mid_swap got %0h/%0d/%b want 0/1/1", od0, ob0, ovl0);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst    = ($urandom_range(99) == 0);
      iHold  = ($urandom_range(7) == 0);
      iClear = ($urandom_range(15) == 0);
      iSwap  = ($urandom_range(5) == 0);
      iValid = ($urandom_range(3) != 0);
      set_rand();
      tick();
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs_valid[d] !== m_valid[d] || obs_bank[d] !== 32'(m_ptr[d]))
          $display("FAIL rand_ctrl cyc%0d dut%0d got %b/%0d want %b/%0d",
                   c, d, obs_valid[d], obs_bank[d], m_valid[d], m_ptr[d]);
        else n_pass++;
        for (int k = 0; k < NCH; k++) begin
          n_checks++;
          if (obs_data[d][k] !== exp_data(d, k) || obs_ovf[d][k] !== exp_ovf(d, k))
            $display("FAIL rand_data cyc%0d dut%0d lane%0d got %0h/%b want %0h/%b",
                     c, d, k, obs_data[d][k], obs_ovf[d][k], exp_data(d, k), exp_ovf(d, k));
          else n_pass++;
        end
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    iData = '0;
    idle_inputs();
    test_reset();
    test_accumulate();
    test_wrap3();
    test_signed_sat();
    test_hold();
    test_swap_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
